blob_mover: RTL and testbench

BLOB_MOVER -- requirements
Module: blob_mover

---
 rtl/blob_pkg.sv | 51 +++++
 rtl/frame_tick.sv | 18 +
 rtl/blob_mover.sv | 134 +++++++++++++
 tb/tb_blob_mover.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/blob_pkg.sv
// Shared types and constants for the bouncing-blob mover.
// Honours BLOB_MOVER_PAUSE_EN (adds the PAUSE state).
package blob_pkg;

   localparam int unsigned SCREEN_W_DEF = 1024;
   localparam int unsigned SCREEN_H_DEF = 768;
   localparam int unsigned XW           = 11;
   localparam int unsigned YW           = 10;
   localparam int unsigned CW           = 12;
   localparam int unsigned SPW          = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
`ifdef BLOB_MOVER_PAUSE_EN
      ST_MOVE  = 2'd1,
      ST_PAUSE = 2'd2
`else
      ST_MOVE  = 2'd1
`endif
   } mover_state_t;

   typedef struct packed {
      logic          hit;
      logic          dir;
      logic [CW-1:0] pos;
   } axis_step_t;

   // One frame of motion on one axis; clamps at 0 and lim, flipping direction on contact.
   function automatic axis_step_t axis_step(input logic [CW-1:0]  pos,
                                            input logic [SPW-1:0] spd,
                                            input logic           dir,
                                            input logic [CW-1:0]  lim);
      axis_step_t    step;
      logic [CW-1:0] sum;
      logic [CW-1:0] spd_w;
      spd_w = CW'(spd);
      sum   = pos + spd_w;
      step  = '{hit: 1'b0, dir: dir, pos: pos};
      if (spd != '0) begin
         if (dir) begin
            if (sum >= lim) step = '{hit: 1'b1, dir: 1'b0, pos: lim};
            else            step.pos = sum;
         end else begin
            if (pos <= spd_w) step = '{hit: 1'b1, dir: 1'b1, pos: '0};
            else              step.pos = pos - spd_w;
         end
      end
      return step;
   endfunction

endpackage

// File: rtl/frame_tick.sv
// Registers vsync and flags its falling edge as a once-per-frame tick.
module frame_tick (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_vsync,
   output logic o_tick_c
);

   logic r_vsync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_vsync <= 1'b1;
      else          r_vsync <= i_vsync;
   end

   assign o_tick_c = r_vsync & ~i_vsync;

endmodule

// File: rtl/blob_mover.sv
// Moves a blob one speed step per frame, bouncing off the screen edges.
// Define BLOB_MOVER_PAUSE_EN to add the pause input and PAUSE state.
import blob_pkg::*;

module blob_mover #(
   parameter int unsigned WIDTH    = 64,
   parameter int unsigned HEIGHT   = 64,
   parameter int unsigned SCREEN_W = SCREEN_W_DEF,
   parameter int unsigned SCREEN_H = SCREEN_H_DEF
) (
   input  logic           vclock,
   input  logic           reset_n,
   input  logic           vsync,
   input  logic           launch,
   input  logic           stop,
`ifdef BLOB_MOVER_PAUSE_EN
   input  logic           pause,
`endif
   input  logic           load,
   input  logic [XW-1:0]  x_in,
   input  logic [YW-1:0]  y_in,
   input  logic [SPW-1:0] speed_x,
   input  logic [SPW-1:0] speed_y,
   output logic [XW-1:0]  x,
   output logic [YW-1:0]  y,
   output logic           dir_x,
   output logic           dir_y,
   output logic           bounce,
   output logic           moving
);

   localparam logic [CW-1:0] XL = CW'(SCREEN_W - WIDTH);
   localparam logic [CW-1:0] YL = CW'(SCREEN_H - HEIGHT);

   mover_state_t   r_state;
   mover_state_t   w_state_nx;
   logic [CW-1:0]  r_x;
   logic [CW-1:0]  r_y;
   logic [SPW-1:0] r_spd_x;
   logic [SPW-1:0] r_spd_y;
   logic           r_dir_x;
   logic           r_dir_y;
   logic           r_bounce;
   logic           r_moving;
   logic           w_tick;
   logic           w_pause;
   logic           w_apply;
   logic [CW-1:0]  w_x_ld;
   logic [CW-1:0]  w_y_ld;
   axis_step_t     w_sx;
   axis_step_t     w_sy;

`ifdef BLOB_MOVER_PAUSE_EN
   assign w_pause = pause;
`else
   assign w_pause = 1'b0;
`endif

   frame_tick u_frame_tick (
      .i_clk    (vclock),
      .i_rst_n  (reset_n),
      .i_vsync  (vsync),
      .o_tick_c (w_tick)
   );

   // Candidate positions for this frame and clamped load values.
   assign w_sx    = axis_step(r_x, r_spd_x, r_dir_x, XL);
   assign w_sy    = axis_step(r_y, r_spd_y, r_dir_y, YL);
   assign w_x_ld  = (CW'(x_in) > XL) ? XL : CW'(x_in);
   assign w_y_ld  = (CW'(y_in) > YL) ? YL : CW'(y_in);

   // A load or a leaving transition wins over the frame's motion.
   assign w_apply = w_tick & (r_state == ST_MOVE) & ~stop & ~w_pause & ~load;

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         ST_IDLE: if (launch && !stop) w_state_nx = ST_MOVE;
         ST_MOVE: begin
            if (stop) w_state_nx = ST_IDLE;
`ifdef BLOB_MOVER_PAUSE_EN
            else if (w_pause) w_state_nx = ST_PAUSE;
`endif
         end
`ifdef BLOB_MOVER_PAUSE_EN
         ST_PAUSE: begin
            if (stop)          w_state_nx = ST_IDLE;
            else if (!w_pause) w_state_nx = ST_MOVE;
         end
`endif
         default: w_state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge vclock or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_x      <= XL >> 1;
         r_y      <= YL >> 1;
         r_spd_x  <= SPW'(2);
         r_spd_y  <= SPW'(2);
         r_dir_x  <= 1'b1;
         r_dir_y  <= 1'b1;
         r_bounce <= 1'b0;
         r_moving <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_moving <= (w_state_nx == ST_MOVE);
         r_bounce <= 1'b0;
         if (load) begin
            r_x     <= w_x_ld;
            r_y     <= w_y_ld;
            r_spd_x <= speed_x;
            r_spd_y <= speed_y;
            r_dir_x <= 1'b1;
            r_dir_y <= 1'b1;
         end else if (w_apply) begin
            r_x      <= w_sx.pos;
            r_y      <= w_sy.pos;
            r_dir_x  <= w_sx.dir;
            r_dir_y  <= w_sy.dir;
            r_bounce <= w_sx.hit | w_sy.hit;
         end
      end
   end

   assign x      = r_x[XW-1:0];
   assign y      = r_y[YW-1:0];
   assign dir_x  = r_dir_x;
   assign dir_y  = r_dir_y;
   assign bounce = r_bounce;
   assign moving = r_moving;

endmodule

// File: tb/tb_blob_mover.sv
// Randomised and directed checks of blob_mover against a frame-level reference model.
module tb_blob_mover;

   localparam int XL = 960;
   localparam int YL = 704;

   logic        vclock = 1'b0;
   logic        reset_n;
   logic        vsync;
   logic        launch;
   logic        stop;
   logic        load;
   logic [10:0] x_in;
   logic [9:0]  y_in;
   logic [3:0]  speed_x;
   logic [3:0]  speed_y;
   logic [10:0] x;
   logic [9:0]  y;
   logic        dir_x;
   logic        dir_y;
   logic        bounce;
   logic        moving;
`ifdef BLOB_MOVER_PAUSE_EN
   logic        pause;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: position, direction, speed, mode (0 idle, 1 move, 2 pause).
   int m_x, m_y, m_dx, m_dy, m_sx, m_sy, m_st, m_b, m_vs;

   int fr_len, fr_pos, lo_len;
   bit r_ps;

   blob_mover dut (
      .vclock  (vclock),
      .reset_n (reset_n),
      .vsync   (vsync),
      .launch  (launch),
      .stop    (stop),
`ifdef BLOB_MOVER_PAUSE_EN
      .pause   (pause),
`endif
      .load    (load),
      .x_in    (x_in),
      .y_in    (y_in),
      .speed_x (speed_x),
      .speed_y (speed_y),
      .x       (x),
      .y       (y),
      .dir_x   (dir_x),
      .dir_y   (dir_y),
      .bounce  (bounce),
      .moving  (moving)
   );

   always #5 vclock = ~vclock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_x = XL / 2; m_y = YL / 2;
      m_sx = 2; m_sy = 2; m_dx = 1; m_dy = 1;
      m_st = 0; m_b = 0; m_vs = 1;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "_x"},      32'(x),      32'(m_x));
      check({tag, "_y"},      32'(y),      32'(m_y));
      check({tag, "_dir_x"},  32'(dir_x),  32'(m_dx));
      check({tag, "_dir_y"},  32'(dir_y),  32'(m_dy));
      check({tag, "_bounce"}, 32'(bounce), 32'(m_b));
      check({tag, "_moving"}, 32'(moving), 32'(m_st == 1));
   endtask

   task automatic axis(inout int p, inout int d, input int s, input int lim, output bit hit);
      hit = 1'b0;
      if (s == 0) return;
      if (d == 1) begin
         if (p + s >= lim) begin p = lim; d = 0; hit = 1'b1; end
         else p = p + s;
      end else begin
         if (p <= s) begin p = 0; d = 1; hit = 1'b1; end
         else p = p - s;
      end
   endtask

   // Drive one cycle of inputs, advance the model, clock, and compare.
   task automatic step(input bit vs, input bit ld, input bit lau, input bit stp, input bit ps,
                       input int xi, input int yi, input int sxi, input int syi);
      bit tick, hx, hy, psx;
      psx = ps;
`ifdef BLOB_MOVER_PAUSE_EN
      pause = ps;
`else
      psx = 1'b0;
`endif
      vsync = vs; load = ld; launch = lau; stop = stp;
      x_in = 11'(xi); y_in = 10'(yi); speed_x = 4'(sxi); speed_y = 4'(syi);
      tick = (m_vs == 1) && !vs;
      m_vs = vs ? 1 : 0;
      m_b  = 0;
      if (ld) begin
         m_x = (xi > XL) ? XL : xi;
         m_y = (yi > YL) ? YL : yi;
         m_sx = sxi; m_sy = syi; m_dx = 1; m_dy = 1;
      end else if (tick && m_st == 1 && !stp && !psx) begin
         axis(m_x, m_dx, m_sx, XL, hx);
         axis(m_y, m_dy, m_sy, YL, hy);
         m_b = (hx || hy) ? 1 : 0;
      end
      case (m_st)
         0: if (lau && !stp) m_st = 1;
         1: if (stp) m_st = 0; else if (psx) m_st = 2;
         default: if (stp) m_st = 0; else if (!psx) m_st = 1;
      endcase
      @(posedge vclock);
      #1;
      check_outputs("cyc");
   endtask

   task automatic idle(input bit vs);
      step(vs, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic tick_frame();
      idle(0);
      idle(1);
   endtask

   task automatic async_reset();
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      check_outputs("arst");
      @(posedge vclock);
      #1;
      check_outputs("arst_hold");
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b1;
      vsync = 1'b1; launch = 1'b0; stop = 1'b0; load = 1'b0;
      x_in = '0; y_in = '0; speed_x = '0; speed_y = '0;
`ifdef BLOB_MOVER_PAUSE_EN
      pause = 1'b0;
`endif
      model_reset();
      #1 reset_n = 1'b0;
      #2;
      check("rst_x", 32'(x), 32'd480);
      check("rst_y", 32'(y), 32'd352);
      check("rst_moving", 32'(moving), 32'd0);
      check("rst_bounce", 32'(bounce), 32'd0);
      check("rst_dir", 32'({dir_x, dir_y}), 32'd3);
      repeat (2) @(posedge vclock);
      #1 reset_n = 1'b1;

      // Idle frames leave the blob parked.
      repeat (5) tick_frame();
      check("idle_x", 32'(x), 32'd480);
      check("idle_y", 32'(y), 32'd352);
      check("idle_moving", 32'(moving), 32'd0);

      // Load then launch: two frames of motion.
      step(1, 1, 0, 0, 0, 100, 200, 3, 2);
      step(1, 0, 1, 0, 0, 0, 0, 0, 0);
      repeat (2) tick_frame();
      check("run_x", 32'(x), 32'd106);
      check("run_y", 32'(y), 32'd204);
      check("run_dir", 32'({dir_x, dir_y}), 32'd3);

      // Right-wall clamp, bounce pulse, then retreat.
      step(1, 1, 0, 0, 0, 958, 204, 4, 0);
      idle(0);
      check("rwall_x", 32'(x), 32'd960);
      check("rwall_dir_x", 32'(dir_x), 32'd0);
      check("rwall_bounce", 32'(bounce), 32'd1);
      idle(1);
      check("rwall_bounce_end", 32'(bounce), 32'd0);
      idle(0);
      check("rwall_back_x", 32'(x), 32'd956);
      idle(1);

      // Corner hit on both axes gives one pulse.
      step(1, 1, 0, 0, 0, 957, 701, 3, 3);
      idle(0);
      check("corner_pos", 32'({x, y}), 32'({11'd960, 10'd704}));
      check("corner_dir", 32'({dir_x, dir_y}), 32'd0);
      check("corner_bounce", 32'(bounce), 32'd1);
      idle(1);
      check("corner_bounce_end", 32'(bounce), 32'd0);

      // Left wall reached with x equal to speed.
      repeat (319) tick_frame();
      check("lwall_pre_x", 32'(x), 32'd3);
      idle(0);
      check("lwall_x", 32'(x), 32'd0);
      check("lwall_dir_x", 32'(dir_x), 32'd1);
      check("lwall_bounce", 32'(bounce), 32'd1);
      idle(1);

      // Load coinciding with a tick clamps and suppresses motion.
      step(0, 1, 0, 0, 0, 2000, 100, 5, 5);
      check("ldtick_x", 32'(x), 32'd960);
      check("ldtick_y", 32'(y), 32'd100);
      check("ldtick_bounce", 32'(bounce), 32'd0);
      idle(1);
      step(1, 0, 1, 1, 0, 0, 0, 0, 0);
      check("stop_launch_move", 32'(moving), 32'd0);
      step(1, 0, 1, 1, 0, 0, 0, 0, 0);
      check("stop_launch_idle", 32'(moving), 32'd0);
      tick_frame();
      check("stopped_x", 32'(x), 32'd960);

      // Reset while moving, then the first frame leaves the blob centred.
      step(1, 0, 1, 0, 0, 0, 0, 0, 0);
      tick_frame();
      async_reset();
      check("mid_rst_x", 32'(x), 32'd480);
      check("mid_rst_moving", 32'(moving), 32'd0);
      tick_frame();
      check("post_rst_x", 32'(x), 32'd480);
      check("post_rst_y", 32'(y), 32'd352);

`ifdef BLOB_MOVER_PAUSE_EN
      step(1, 1, 0, 0, 0, 300, 300, 5, 7);
      step(1, 0, 1, 0, 0, 0, 0, 0, 0);
      repeat (3) begin
         step(0, 0, 0, 0, 1, 0, 0, 0, 0);
         step(1, 0, 0, 0, 1, 0, 0, 0, 0);
      end
      check("pause_x", 32'(x), 32'd300);
      check("pause_moving", 32'(moving), 32'd0);
      idle(1);
      tick_frame();
      check("resume_x", 32'(x), 32'd305);
      check("resume_y", 32'(y), 32'd307);
`endif

      // Random traffic with frames of varying length.
      fr_pos = 0; fr_len = 4; lo_len = 1; r_ps = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         bit vs, ld, lau, stp;
         if (fr_pos == 0) begin
            fr_len = int'($urandom_range(4, 12));
            lo_len = int'($urandom_range(1, 3));
         end
         vs  = (fr_pos >= lo_len);
         fr_pos = (fr_pos + 1 == fr_len) ? 0 : fr_pos + 1;
         ld  = ($urandom_range(0, 39) == 0);
         lau = ($urandom_range(0, 19) == 0);
         stp = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 29) == 0) r_ps = ~r_ps;
         if (c == 1500) async_reset();
         step(vs, ld, lau, stp, r_ps,
              int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
